cpu_control_fsm: RTL

Multicycle control unit for the CPU datapath. It sequences the 12-bit program counter, the 19-bit instruction register, the 8-bit register file/flag registers and the shared single-port memory through fetch, decode, execute and writeback. It handshakes with memory through a ready signal, so wait states stretch any memory step. It sits beside the datapath and drives every load enable and mux select.

---
 rtl/cpu_control_fsm_if.sv | 61 ++++++
 rtl/cpu_control_fsm.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_fsm_if.sv
// -----------------------------------------------------------------------------
// cpu_control_fsm_if
//
// Bundles the signals that pass between the multicycle control unit and the
// datapath/memory side.
//
//   Datapath -> controller:
//     ir        [18:0]  instruction register contents (opcode = ir[18:16],
//                       ALU function = ir[15:13])
//     zero              zero flag from the datapath flag register
//     mem_ready         memory finished the requested read/write this cycle
//   Controller -> datapath:
//     mem_rd, mem_wr    memory read / write requests (held until mem_ready)
//     addr_sel          0 = address from PC, 1 = address from ir[11:0]
//     ir_ld, pc_ld      instruction register / PC load enables
//     pc_sel            0 = PC+1, 1 = ir[11:0]
//     rf_we             register file write enable
//     wb_sel            0 = ALU result, 1 = memory data
//     b_sel             0 = register operand, 1 = immediate ir[7:0]
//     alu_op    [2:0]   ALU function
//     flags_ld          load zero/carry flags
//     halted            controller is in HALT
//     instret   [CNT_W-1:0] retired-instruction count
//
// master: the controller.  slave: the datapath/memory side.
// -----------------------------------------------------------------------------
interface cpu_control_fsm_if #(
  parameter int CNT_W = 16
);

  logic [18:0]      ir;
  logic             zero;
  logic             mem_ready;

  logic             mem_rd;
  logic             mem_wr;
  logic             addr_sel;
  logic             ir_ld;
  logic             pc_ld;
  logic             pc_sel;
  logic             rf_we;
  logic             wb_sel;
  logic             b_sel;
  logic [2:0]       alu_op;
  logic             flags_ld;
  logic             halted;
  logic [CNT_W-1:0] instret;

  modport master (
    input  ir, zero, mem_ready,
    output mem_rd, mem_wr, addr_sel, ir_ld, pc_ld, pc_sel, rf_we, wb_sel,
           b_sel, alu_op, flags_ld, halted, instret
  );

  modport slave (
    output ir, zero, mem_ready,
    input  mem_rd, mem_wr, addr_sel, ir_ld, pc_ld, pc_sel, rf_we, wb_sel,
           b_sel, alu_op, flags_ld, halted, instret
  );

endinterface

// File: rtl/cpu_control_fsm.sv
// -----------------------------------------------------------------------------
// cpu_control_fsm
//
// Multicycle control unit. Sequences fetch, decode, execute, memory access and
// writeback for the CPU datapath, stretching memory steps while mem_ready is
// low, and counts retired instructions.
//
// Ports:
//   clk   system clock, all state changes on the rising edge
//   rst   asynchronous, active-low reset
//   bus   cpu_control_fsm_if.master: instruction/flag/ready inputs and every
//         datapath control output (see the interface file)
//
// Parameters:
//   CNT_W width of the retired-instruction counter (wraps at 2^CNT_W)
// -----------------------------------------------------------------------------
module cpu_control_fsm #(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  cpu_control_fsm_if.master  bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEMRD  = 3'd3,
    S_WB     = 3'd4,
    S_MEMWR  = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    OP_ALU   = 3'b000,
    OP_ALUI  = 3'b001,
    OP_LOAD  = 3'b010,
    OP_STORE = 3'b011,
    OP_JUMP  = 3'b100,
    OP_BZ    = 3'b101,
    OP_NOP   = 3'b110,
    OP_HALT  = 3'b111
  } opcode_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;
  opcode_e          opcode;

  assign opcode = opcode_e'(bus.ir[18:16]);

  // ---------------------------------------------------------------------------
  // State register and retired-instruction counter
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs, independent of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and retire decode
  // ---------------------------------------------------------------------------
  // NOTE: every variable written here is given a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) state_d = S_DECODE;
      end

      S_DECODE: begin
        case (opcode)
          OP_ALU, OP_ALUI: state_d = S_EXEC;
          OP_LOAD:         state_d = S_MEMRD;
          OP_STORE:        state_d = S_MEMWR;
          OP_JUMP, OP_BZ, OP_NOP: begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OP_HALT:         state_d = S_HALT;
          default:         state_d = S_FETCH;
        endcase
      end

      S_EXEC: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end

      S_MEMRD: begin
        if (bus.mem_ready) state_d = S_WB;
      end

      S_WB: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end

      S_MEMWR: begin
        if (bus.mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_HALT: state_d = S_HALT;

      // Unused encoding: restart cleanly from fetch.
      default: state_d = S_FETCH;
    endcase
  end

  // Counter wraps naturally from all-ones to zero.
  assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  // The async reset puts state_q in FETCH, which would otherwise request a
  // read; gating with rst keeps every control at 0 for as long as reset is
  // held, so an interrupted cycle cannot leave a partial write pulse.
  always_comb begin
    bus.mem_rd   = 1'b0;
    bus.mem_wr   = 1'b0;
    bus.addr_sel = 1'b0;
    bus.ir_ld    = 1'b0;
    bus.pc_ld    = 1'b0;
    bus.pc_sel   = 1'b0;
    bus.rf_we    = 1'b0;
    bus.wb_sel   = 1'b0;
    bus.b_sel    = 1'b0;
    bus.alu_op   = 3'b000;
    bus.flags_ld = 1'b0;
    bus.halted   = 1'b0;

    if (rst) begin
      case (state_q)
        S_FETCH: begin
          bus.mem_rd = 1'b1;
          // IR and PC+1 are captured on the edge that completes the read.
          if (bus.mem_ready) begin
            bus.ir_ld = 1'b1;
            bus.pc_ld = 1'b1;
          end
        end

        S_DECODE: begin
          if (opcode == OP_JUMP || (opcode == OP_BZ && bus.zero)) begin
            bus.pc_ld  = 1'b1;
            bus.pc_sel = 1'b1;
          end
        end

        S_EXEC: begin
          bus.alu_op   = bus.ir[15:13];
          bus.b_sel    = (opcode == OP_ALUI);
          bus.rf_we    = 1'b1;
          bus.flags_ld = 1'b1;
        end

        S_MEMRD: begin
          bus.mem_rd   = 1'b1;
          bus.addr_sel = 1'b1;
        end

        S_WB: begin
          bus.rf_we  = 1'b1;
          bus.wb_sel = 1'b1;
        end

        S_MEMWR: begin
          bus.mem_wr   = 1'b1;
          bus.addr_sel = 1'b1;
        end

        S_HALT: bus.halted = 1'b1;

        default: ;
      endcase
    end
  end

  assign bus.instret = instret_q;

  // ---------------------------------------------------------------------------
  // Structural invariants of the control decode
  // ---------------------------------------------------------------------------
  a_rd_wr_excl : assert property (@(posedge clk) disable iff (!rst)
    !(bus.mem_rd && bus.mem_wr));

  a_we_pc_excl : assert property (@(posedge clk) disable iff (!rst)
    !(bus.rf_we && bus.pc_ld));

endmodule
